// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and default depth for the memory responder.
package mem_pkg;
   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   localparam int MEM_DEPTH_WORDS = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;
endpackage

// File: rtl/word_ram.sv
// Word array with a 4-bit byte-enable write port and a registered read port.
// One access per cycle; no flow control, the caller sequences reads and writes.
module word_ram #(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic          re,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH_WORDS];

   // Contents survive reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_responder.sv
// Byte/half/word memory responder with fault detection; ready pulses 1 cycle after accept
// (1+WAIT_CYCLES when MEM_WAIT_EN is defined). Requests outside IDLE are ignored until ready.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] out,
   output logic        error,
   output logic        ready
);
   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

   mem_state_t  state;
   logic        lat_we, lat_re, lat_sign;
   logic [31:0] lat_addr, lat_data;
   logic [1:0]  lat_size;

   logic        in_idle, to_resp, wait_done;
   logic        cur_we, cur_re, cur_err;
   logic [31:0] cur_addr, cur_data;
   logic [1:0]  cur_size;
   logic        ram_we, ram_re;
   logic [3:0]  ram_be;
   logic [31:0] ram_wdata, ram_rdata, rd_ext;

`ifdef MEM_WAIT_EN
   localparam bit WAIT_ON = (WAIT_CYCLES > 0);
   logic [31:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 32'd1;
      else                       wait_cnt <= '0;
   end

   assign wait_done = (state == ST_WAIT) && (wait_cnt == 32'(WAIT_CYCLES - 1));
`else
   localparam bit WAIT_ON = 1'b0 && (WAIT_CYCLES > 0);
   assign wait_done = 1'b0;
`endif

   // The access being completed is the live request in IDLE, else the latched one.
   assign in_idle  = (state == ST_IDLE);
   assign cur_we   = in_idle ? we   : lat_we;
   assign cur_re   = in_idle ? re   : lat_re;
   assign cur_addr = in_idle ? addr : lat_addr;
   assign cur_data = in_idle ? data : lat_data;
   assign cur_size = in_idle ? size : lat_size;
   assign to_resp  = (in_idle && (we || re) && !WAIT_ON) || wait_done;

   always_comb begin
      cur_err   = 1'b0;
      ram_be    = 4'b0000;
      ram_wdata = cur_data;
      case (cur_size)
         MEM_BYTE: begin
            ram_be    = 4'b0001 << cur_addr[1:0];
            ram_wdata = {4{cur_data[7:0]}};
         end
         MEM_HALF: begin
            cur_err   = cur_addr[0];
            ram_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{cur_data[15:0]}};
         end
         MEM_WORD: begin
            cur_err = (cur_addr[1:0] != 2'b00);
            ram_be  = 4'b1111;
         end
         default: cur_err = 1'b1;
      endcase
      if ({1'b0, cur_addr} >= ADDR_LIMIT) cur_err = 1'b1;
      if (cur_we && cur_re)                cur_err = 1'b1;
   end

   // Commit on entry to RESP; reset suppresses a commit that coincides with it.
   assign ram_we = to_resp && cur_we && !cur_err && !rst;
   assign ram_re = to_resp && cur_re && !cur_err && !rst;

   word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (ram_be),
      .addr  (cur_addr[AW+1:2]),
      .wdata (ram_wdata),
      .re    (ram_re),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ready    <= 1'b0;
         error    <= 1'b0;
         lat_we   <= 1'b0;
         lat_re   <= 1'b0;
         lat_sign <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
         lat_size <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (we || re) begin
                  lat_we   <= we;
                  lat_re   <= re;
                  lat_sign <= sign;
                  lat_addr <= addr;
                  lat_data <= data;
                  lat_size <= size;
                  if (WAIT_ON) begin
                     state <= ST_WAIT;
                  end else begin
                     state <= ST_RESP;
                     ready <= 1'b1;
                     error <= cur_err;
                  end
               end
            end
`ifdef MEM_WAIT_EN
            ST_WAIT: begin
               if (wait_done) begin
                  state <= ST_RESP;
                  ready <= 1'b1;
                  error <= cur_err;
               end
            end
`endif
            ST_RESP: begin
               state <= ST_IDLE;
               ready <= 1'b0;
               error <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b0;
               error <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      case (lat_size)
         MEM_BYTE: begin
            logic [7:0] b;
            b      = 8'(ram_rdata >> {lat_addr[1:0], 3'b000});
            rd_ext = lat_sign ? {24'h0, b} : {{24{b[7]}}, b};
         end
         MEM_HALF: begin
            logic [15:0] h;
            h      = lat_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
            rd_ext = lat_sign ? {16'h0, h} : {{16{h[15]}}, h};
         end
         default: rd_ext = ram_rdata;
      endcase
   end

   assign out = (ready && !error && lat_re) ? rd_ext : 32'h0;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hold/reset sequences.
module tb_mem_responder;
   import mem_pkg::*;

`ifdef MEM_WAIT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0, re = 1'b0, sign = 1'b0;
   logic [31:0] addr = '0, data = '0;
   logic [1:0]  size = '0;
   logic [31:0] out;
   logic        error, ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        we, re;
      logic [31:0] addr, data;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] exp_out;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] out;
      logic        err;
   } exp_t;

   exp_t sb[$];

   mem_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data(data),
      .size(size), .sign(sign), .out(out), .error(error), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      we = v.we; re = v.re; addr = v.addr; data = v.data; size = v.size; sign = v.sign;
      sb.push_back('{out: v.exp_out, err: v.exp_err});
   endtask

   task automatic idle_inputs();
      we = 1'b0; re = 1'b0;
   endtask

   // Waits for ready after the request is presented, compares against scoreboard head.
   task automatic await_resp(input string name, input int exp_lat);
      int   cyc;
      bit   got;
      exp_t e;
      cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (ready) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no ready within %0d cycles", name, cyc);
         if (sb.size() > 0) void'(sb.pop_front());
         idle_inputs();
         return;
      end
      e = sb.pop_front();
      chk({name, "_out"}, out, e.out);
      chk({name, "_err"}, 32'(error), 32'(e.err));
      chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
      idle_inputs();
      @(posedge clk); #1;
      chk({name, "_strobe"}, 32'(ready), 32'd0);
   endtask

   task automatic access(input vec_t v);
      @(negedge clk);
      drive(v);
      await_resp(v.name, LAT);
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{"wr_word",   1, 0, 32'h100,  32'hDEADBEEF, MEM_WORD, 0, 32'h0,        0},
         '{"rd_word",   0, 1, 32'h100,  32'h0,        MEM_WORD, 0, 32'hDEADBEEF, 0},
         '{"rd_b3_sx",  0, 1, 32'h103,  32'h0,        MEM_BYTE, 0, 32'hFFFFFFDE, 0},
         '{"rd_b3_zx",  0, 1, 32'h103,  32'h0,        MEM_BYTE, 1, 32'h000000DE, 0},
         '{"rd_b0_sx",  0, 1, 32'h100,  32'h0,        MEM_BYTE, 0, 32'hFFFFFFEF, 0},
         '{"rd_h0_zx",  0, 1, 32'h100,  32'h0,        MEM_HALF, 1, 32'h0000BEEF, 0},
         '{"rd_h0_sx",  0, 1, 32'h100,  32'h0,        MEM_HALF, 0, 32'hFFFFBEEF, 0},
         '{"wr_half2",  1, 0, 32'h102,  32'hFFFF1234, MEM_HALF, 0, 32'h0,        0},
         '{"rd_after_h",0, 1, 32'h100,  32'h0,        MEM_WORD, 0, 32'h1234BEEF, 0},
         '{"rd_h2_sx",  0, 1, 32'h102,  32'h0,        MEM_HALF, 0, 32'h00001234, 0},
         '{"wr_byte1",  1, 0, 32'h101,  32'hFFFFFFAA, MEM_BYTE, 0, 32'h0,        0},
         '{"rd_after_b",0, 1, 32'h100,  32'h0,        MEM_WORD, 0, 32'h1234AAEF, 0},
         '{"f_rd_mis",  0, 1, 32'h101,  32'h0,        MEM_WORD, 0, 32'h0,        1},
         '{"f_wr_mis",  1, 0, 32'h101,  32'h0,        MEM_WORD, 0, 32'h0,        1},
         '{"f_h_odd",   0, 1, 32'h103,  32'h0,        MEM_HALF, 0, 32'h0,        1},
         '{"f_size11",  0, 1, 32'h100,  32'h0,        2'b11,    0, 32'h0,        1},
         '{"f_wr_sz11", 1, 0, 32'h100,  32'h0,        2'b11,    0, 32'h0,        1},
         '{"f_rd_oob",  0, 1, 32'h4000, 32'h0,        MEM_WORD, 0, 32'h0,        1},
         '{"f_wr_oob",  1, 0, 32'h4000, 32'h0,        MEM_WORD, 0, 32'h0,        1},
         '{"f_we_re",   1, 1, 32'h100,  32'h0,        MEM_WORD, 0, 32'h0,        1},
         '{"rd_intact", 0, 1, 32'h100,  32'h0,        MEM_WORD, 0, 32'h1234AAEF, 0},
         '{"wr_last",   1, 0, 32'h3FFC, 32'hCAFEF00D, MEM_WORD, 0, 32'h0,        0},
         '{"rd_last",   0, 1, 32'h3FFC, 32'h0,        MEM_WORD, 0, 32'hCAFEF00D, 0},
         '{"rd_lastb",  0, 1, 32'h3FFF, 32'h0,        MEM_BYTE, 1, 32'h000000CA, 0},
         '{"wr_200",    1, 0, 32'h200,  32'h11111111, MEM_WORD, 0, 32'h0,        0}
      };

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_out",   out,        32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) access(vecs[i]);

      // Second request held from the first acceptance: it must wait for IDLE.
      begin
         int   cyc;
         int   seen;
         exp_t e;
         @(negedge clk);
         drive('{"held_a", 0, 1, 32'h100, 32'h0, MEM_WORD, 0, 32'h1234AAEF, 0});
         @(posedge clk); #1;
         cyc = 1; seen = 0;
         drive('{"held_b", 0, 1, 32'h102, 32'h0, MEM_BYTE, 1, 32'h00000034, 0});
         while (seen < 2 && cyc < 40) begin
            if (ready) begin
               e = sb.pop_front();
               seen++;
               chk(seen == 1 ? "held_a_out" : "held_b_out", out, e.out);
               chk(seen == 1 ? "held_a_lat" : "held_b_lat", 32'(cyc),
                   seen == 1 ? 32'(LAT) : 32'(2 * LAT + 1));
               if (seen == 2) idle_inputs();
            end
            if (seen < 2) begin
               @(posedge clk); #1;
               cyc++;
            end
         end
         if (seen < 2) begin
            checks++; errors++;
            $display("FAIL held_timeout: responses seen %0d expected 2", seen);
            idle_inputs();
            sb.delete();
         end
         @(posedge clk); #1;
         chk("held_strobe", 32'(ready), 32'd0);
      end

      // Reset lands on an in-flight write of 0x55 to 0x200; the write must vanish.
      begin
         int rdy_cnt;
         rdy_cnt = 0;
         @(negedge clk);
         we = 1'b1; re = 1'b0; addr = 32'h200; data = 32'h55; size = MEM_WORD; sign = 1'b0;
`ifdef MEM_WAIT_EN
         @(posedge clk); #1;
         if (ready) rdy_cnt++;
         @(negedge clk);
`endif
         rst = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ready) rdy_cnt++;
         end
         chk("rst_no_ready", 32'(rdy_cnt), 32'd0);
         chk("rst_mid_out", out, 32'd0);
         @(negedge clk);
         idle_inputs();
         rst = 1'b0;
         drive('{"rd_200_after_rst", 0, 1, 32'h200, 32'h0, MEM_WORD, 0, 32'h11111111, 0});
         await_resp("rd_200_after_rst", LAT);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
